// File: rtl/core_pkg.sv
// core_pkg: types and default widths shared by the fetch sequencer and the
// PC/decode logic.
//   seq_state_t : fetch sequencer FSM state encoding
//   IW_DEF      : default instruction width
//   IMW_DEF     : default instruction-memory address width
//   CW_DEF      : default retired-instruction counter width
package core_pkg;

   localparam int IW_DEF  = 8;
   localparam int IMW_DEF = 4;
   localparam int CW_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      ISSUE  = 2'd2,
      HALTED = 2'd3
   } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter used for retired-instruction and other
// core performance counters.
//   clk   : clock, all updates on rising edge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, takes priority over inc
//   inc   : increment by one, holding at 2^CW-1
//   count : current count
module sat_counter #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {CW{1'b1}})) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: control FSM sequencing instruction fetch and issue.
// Owns the architectural PC, drives the instruction-memory read handshake,
// holds each fetched instruction until execute accepts it, then advances
// the PC (pc+1 or branch target) or stops on HALT. Counts retired
// instructions with a saturating counter.
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : begin execution at 0 (IDLE/HALTED only)
//   imem_req/imem_addr        : instruction read request and address (= pc)
//   imem_valid/imem_data      : read data return (honoured in FETCH only)
//   instr/instr_valid         : instruction presented to execute
//   exec_ready                : execute accepts instr this cycle
//   branch_taken/target, halt : redirect/halt info, sampled on acceptance
//   pc, running, done, retired: status outputs
// All outputs are registers or decodes of the state register.
module fetch_sequencer
   import core_pkg::*;
#(
   parameter int IW  = IW_DEF,
   parameter int IMW = IMW_DEF,
   parameter int CW  = CW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           imem_req,
   output logic [IMW-1:0] imem_addr,
   input  logic           imem_valid,
   input  logic [IW-1:0]  imem_data,
   output logic [IW-1:0]  instr,
   output logic           instr_valid,
   input  logic           exec_ready,
   input  logic           branch_taken,
   input  logic [IMW-1:0] branch_target,
   input  logic           halt,
   output logic [IMW-1:0] pc,
   output logic           running,
   output logic           done,
   output logic [CW-1:0]  retired
);

   seq_state_t     state_q, state_d;
   logic [IMW-1:0] pc_q, pc_d;
   logic [IW-1:0]  instr_q, instr_d;

   logic start_ok;
   logic accept;

   assign start_ok = start && ((state_q == IDLE) || (state_q == HALTED));
   assign accept   = (state_q == ISSUE) && exec_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (imem_valid) state_d = ISSUE;
         ISSUE:   if (exec_ready) state_d = halt ? HALTED : FETCH;
         HALTED:  if (start) state_d = FETCH;
         default: state_d = IDLE;
      endcase
   end

   // output decode from state only
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      running     = 1'b0;
      done        = 1'b0;
      unique case (state_q)
         FETCH:   begin imem_req = 1'b1; running = 1'b1; end
         ISSUE:   begin instr_valid = 1'b1; running = 1'b1; end
         HALTED:  done = 1'b1;
         default: ;
      endcase
   end

   // PC next-value mux; halt wins over branch so pc keeps pointing at HALT
   always_comb begin
      pc_d = pc_q;
      if (start_ok) begin
         pc_d = '0;
      end else if (accept && !halt) begin
         pc_d = branch_taken ? branch_target : pc_q + IMW'(1);
      end
   end

   // instruction hold register, loaded only by a valid return in FETCH
   always_comb begin
      instr_d = instr_q;
      if ((state_q == FETCH) && imem_valid) begin
         instr_d = imem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   sat_counter #(
      .CW (CW)
   ) u_retired (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok),
      .inc   (accept),
      .count (retired)
   );

   assign pc        = pc_q;
   assign imem_addr = pc_q;
   assign instr     = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed testbench for fetch_sequencer. A second
// instance with CW=2 runs in lockstep to exercise retired saturation.
module tb_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       exec_ready = 1'b0;
   logic       branch_taken = 1'b0;
   logic [3:0] branch_target = 4'h0;
   logic       halt = 1'b0;
   logic       zw = 1'b0;
   logic       mv = 1'b0;

   logic       imem_req, instr_valid, running, done;
   logic [3:0] imem_addr, pc;
   logic [7:0] instr, retired, imem_data;
   logic       imem_valid;

   logic       s_imem_req, s_instr_valid, s_running, s_done;
   logic [3:0] s_imem_addr, s_pc;
   logic [7:0] s_instr;
   logic [1:0] s_retired;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // memory model: data = 0x10 + address; zero-wait mode answers every request
   assign imem_data  = 8'h10 + {4'h0, imem_addr};
   assign imem_valid = zw ? imem_req : mv;

   fetch_sequencer #(.IW(8), .IMW(4), .CW(8)) dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .exec_ready(exec_ready),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .pc(pc), .running(running), .done(done), .retired(retired)
   );

   fetch_sequencer #(.IW(8), .IMW(4), .CW(2)) dut_s (
      .clk(clk), .rst(rst), .start(start),
      .imem_req(s_imem_req), .imem_addr(s_imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .instr(s_instr), .instr_valid(s_instr_valid), .exec_ready(exec_ready),
      .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
      .pc(s_pc), .running(s_running), .done(s_done), .retired(s_retired)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // from FETCH at exp_addr: return data after one cycle, then accept
   task automatic fetch_accept(input logic br, input logic [3:0] tgt,
                               input logic hlt, input logic [3:0] exp_addr);
      chk("fa_req", 32'(imem_req), 32'd1);
      chk("fa_addr", 32'(imem_addr), 32'(exp_addr));
      mv = 1'b1;
      tick();
      mv = 1'b0;
      chk("fa_ivalid", 32'(instr_valid), 32'd1);
      chk("fa_instr", 32'(instr), 32'(8'h10 + {4'h0, exp_addr}));
      exec_ready    = 1'b1;
      branch_taken  = br;
      branch_target = tgt;
      halt          = hlt;
      tick();
      exec_ready    = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 4'h0;
      halt          = 1'b0;
   endtask

   initial begin
      // reset, then idle with stray imem_valid pulses
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_ivalid", 32'(instr_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_instr", 32'(instr), 32'd0);
      for (int i = 0; i < 3; i++) begin
         mv = 1'b1;
         tick();
         mv = 1'b0;
         tick();
         chk("idle_req", 32'(imem_req), 32'd0);
         chk("idle_ivalid", 32'(instr_valid), 32'd0);
         chk("idle_instr", 32'(instr), 32'd0);
      end

      // straight-line, zero-wait memory, exec always ready
      zw = 1'b1;
      exec_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("sl_req", 32'(imem_req), 32'd1);
         chk("sl_addr", 32'(imem_addr), 32'(i));
         tick();
         chk("sl_ivalid", 32'(instr_valid), 32'd1);
         chk("sl_instr", 32'(instr), 32'(8'h10 + i));
         tick();
         chk("sl_retired", 32'(retired), 32'(i + 1));
      end
      zw = 1'b0;
      exec_ready = 1'b0;
      chk("sat_retired", 32'(s_retired), 32'd3);

      // wait states at pc=5, then 2-cycle backpressure
      for (int i = 0; i < 3; i++) begin
         chk("ws_req", 32'(imem_req), 32'd1);
         chk("ws_addr", 32'(imem_addr), 32'd5);
         tick();
      end
      mv = 1'b1;
      tick();
      mv = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("bp_ivalid", 32'(instr_valid), 32'd1);
         chk("bp_instr", 32'(instr), 32'h15);
         chk("bp_retired", 32'(retired), 32'd5);
         tick();
      end
      exec_ready = 1'b1;
      tick();
      exec_ready = 1'b0;
      chk("bp_pc", 32'(pc), 32'd6);
      chk("bp_retired1", 32'(retired), 32'd6);
      tick();
      chk("bp_retired2", 32'(retired), 32'd6);

      // branch to 3, branch from 3 to 0xE, then wrap 0xF -> 0x0
      fetch_accept(1'b1, 4'h3, 1'b0, 4'h6);
      fetch_accept(1'b1, 4'hE, 1'b0, 4'h3);
      chk("br_addr", 32'(imem_addr), 32'hE);
      fetch_accept(1'b0, 4'h0, 1'b0, 4'hE);
      chk("br_addrF", 32'(imem_addr), 32'hF);
      fetch_accept(1'b0, 4'h0, 1'b0, 4'hF);
      chk("wrap_addr", 32'(imem_addr), 32'h0);
      chk("wrap_retired", 32'(retired), 32'd10);

      // halt wins over branch at pc=5
      fetch_accept(1'b1, 4'h5, 1'b0, 4'h0);
      fetch_accept(1'b1, 4'h9, 1'b1, 4'h5);
      chk("h_done", 32'(done), 32'd1);
      chk("h_pc", 32'(pc), 32'd5);
      chk("h_running", 32'(running), 32'd0);
      chk("h_req", 32'(imem_req), 32'd0);
      chk("h_retired", 32'(retired), 32'd12);
      exec_ready = 1'b1;
      mv = 1'b1;
      halt = 1'b1;
      tick();
      tick();
      exec_ready = 1'b0;
      mv = 1'b0;
      halt = 1'b0;
      chk("h_hold_pc", 32'(pc), 32'd5);
      chk("h_hold_ret", 32'(retired), 32'd12);
      chk("h_hold_instr", 32'(instr), 32'h15);
      chk("h_hold_done", 32'(done), 32'd1);
      chk("s_done", 32'(s_done), 32'd1);
      chk("s_pc", 32'(s_pc), 32'd5);
      chk("s_instr", 32'(s_instr), 32'h15);
      chk("s_retired", 32'(s_retired), 32'd3);
      chk("s_req", 32'(s_imem_req), 32'd0);
      chk("s_ivalid", 32'(s_instr_valid), 32'd0);
      chk("s_running", 32'(s_running), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_pc", 32'(pc), 32'd0);
      chk("rs_retired", 32'(retired), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      chk("rs_req", 32'(imem_req), 32'd1);
      chk("rs_addr_s", 32'(s_imem_addr), 32'd0);
      chk("rs_retired_s", 32'(s_retired), 32'd0);

      // reset while fetching, late imem_valid must be ignored
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rf_req0", 32'(imem_req), 32'd0);
      mv = 1'b1;
      tick();
      mv = 1'b0;
      chk("rf_ivalid", 32'(instr_valid), 32'd0);
      chk("rf_req", 32'(imem_req), 32'd0);
      chk("rf_running", 32'(running), 32'd0);
      chk("rf_instr", 32'(instr), 32'd0);
      tick();
      chk("rf_ivalid2", 32'(instr_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
